dmem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the shared 256-bit data memory
//  (enable/write/ack protocol, 10-cycle access). Requester 0 is the I-cache refill port.

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer between the I-cache (m0) and D-cache (m1) refill ports
// and the shared line-wide data memory, with an ack-timeout watchdog.
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              busy_o
);

    localparam int unsigned WdW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapt, StDone} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                cmd_id_q, cmd_id_d;
    logic                cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                err_q, err_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                grant;
    logic                cmd_active;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cmd_id_q     <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_id_q     <= cmd_id_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_id_d     = cmd_id_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        err_d        = err_q;
        wd_d         = wd_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        // On contention the requester that did not win last time gets the grant.
        grant        = (m0_req_i && m1_req_i) ? ~last_grant_q : m1_req_i;

        case (state_q)
            StIdle: begin
                if (m0_req_i || m1_req_i) begin
                    cmd_id_d     = grant;
                    cmd_write_d  = grant ? m1_write_i : m0_write_i;
                    cmd_addr_d   = grant ? m1_addr_i  : m0_addr_i;
                    cmd_wdata_d  = grant ? m1_wdata_i : m0_wdata_i;
                    last_grant_d = grant;
                    err_d        = 1'b0;
                    wd_d         = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (mem_ack_i) begin
                    err_d   = 1'b0;
                    state_d = StCapt;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            StCapt: begin
                if (!cmd_write_q) begin
                    if (cmd_id_q) m1_rdata_d = mem_data_i;
                    else          m0_rdata_d = mem_data_i;
                end
                state_d = StDone;
            end
            StDone: begin
                wd_d    = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_active   = (state_q == StIssue) || (state_q == StWait) || (state_q == StCapt);
        mem_enable_o = (state_q == StIssue);
        mem_write_o  = cmd_active & cmd_write_q;
        mem_addr_o   = cmd_active ? cmd_addr_q  : '0;
        mem_data_o   = cmd_active ? cmd_wdata_q : '0;
        m0_ack_o     = (state_q == StDone) & ~cmd_id_q;
        m1_ack_o     = (state_q == StDone) &  cmd_id_q;
        m0_err_o     = m0_ack_o & err_q;
        m1_err_o     = m1_ack_o & err_q;
        m0_rdata_o   = m0_rdata_q;
        m1_rdata_o   = m1_rdata_q;
        busy_o       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: 10-cycle memory stub plus a line-level model of memory contents
// and per-requester read data, driven by directed and randomised transactions.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          m0_req_i = 1'b0, m0_write_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic [DW-1:0] m0_wdata_i = '0;
    logic          m0_ack_o, m0_err_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_req_i = 1'b0, m1_write_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_wdata_i = '0;
    logic          m1_ack_o, m1_err_o;
    logic [DW-1:0] m1_rdata_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_data_i = '0;
    logic          busy_o;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_rdata_o(m1_rdata_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] ref_rdata [0:1];

    bit            noack = 0, stray = 0;
    bit            mem_pend = 0, data_pend = 0, mem_wr = 0;
    int            mem_cnt = 0;
    int            enables = 0;
    logic [7:0]    mem_line = '0;
    logic [DW-1:0] mem_wd = '0;
    logic [AW-1:0] seen_addr = '0;

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory stub: ack 10 cycles after the enable, read data valid the cycle after ack.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mem_pend  = 0;
            data_pend = 0;
            mem_ack_i = 1'b0;
        end else begin
            mem_ack_i = stray;
            if (data_pend) begin
                mem_data_i = mem[mem_line];
                data_pend  = 0;
            end
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_pend = 0;
                    if (!noack) begin
                        mem_ack_i  = 1'b1;
                        mem_data_i = rnd_line();
                        if (mem_wr) mem[mem_line] = mem_wd;
                        else        data_pend = 1;
                    end
                end
            end
            if (mem_enable_o) begin
                enables++;
                mem_pend  = 1;
                mem_cnt   = 10;
                mem_line  = mem_addr_o[12:5];
                mem_wr    = mem_write_o;
                mem_wd    = mem_data_o;
                seen_addr = mem_addr_o;
            end
        end
    end

    task automatic run_txn(input int id, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int change_at,
                           output int ack_cyc, output int en_cyc, output int n_en,
                           output bit err, output bit other_ack);
        int en_before;
        @(negedge clk_i);
        en_before = enables;
        ack_cyc = -1; en_cyc = -1; err = 0; other_ack = 0;
        if (id == 0) begin
            m0_req_i = 1; m0_write_i = wr; m0_addr_i = addr; m0_wdata_i = wd;
        end else begin
            m1_req_i = 1; m1_write_i = wr; m1_addr_i = addr; m1_wdata_i = wd;
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            if (k == change_at) begin
                if (id == 0) begin m0_addr_i = addr ^ 32'h100; m0_wdata_i = ~wd; end
                else         begin m1_addr_i = addr ^ 32'h100; m1_wdata_i = ~wd; end
            end
            if (mem_enable_o && en_cyc < 0) en_cyc = k;
            if ((id == 0) ? m1_ack_o : m0_ack_o) other_ack = 1;
            if ((id == 0) ? m0_ack_o : m1_ack_o) begin
                ack_cyc = k;
                err = (id == 0) ? m0_err_o : m1_err_o;
                break;
            end
        end
        if (id == 0) m0_req_i = 0; else m1_req_i = 0;
        n_en = enables - en_before;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #2 rst_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, m0_ack_o, m0_err_o,
             m1_ack_o, m1_err_o, m0_rdata_o, m1_rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b en=%b addr=%h not all zero",
                     busy_o, mem_enable_o, mem_addr_o);
        end
        @(negedge clk_i);
        #2 rst_i = 1;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_read_latency();
        int a, e, n; bit er, oth;
        mem[2] = {32{8'hA5}}; ref_mem[2] = {32{8'hA5}};
        run_txn(0, 0, 32'h40, '0, 0, a, e, n, er, oth);
        ref_rdata[0] = ref_mem[2];
        checks++; if (e !== 1) begin errors++; $display("FAIL t1_enable_cycle: got %0d want 1", e); end
        checks++; if (n !== 1) begin errors++; $display("FAIL t1_enable_count: got %0d want 1", n); end
        checks++; if (a !== 13) begin errors++; $display("FAIL t1_ack_cycle: got %0d want 13", a); end
        checks++; if (er !== 0) begin errors++; $display("FAIL t1_err: got %0d want 0", er); end
        checks++; if (oth !== 0) begin errors++; $display("FAIL t1_m1_ack: got %0d want 0", oth); end
        checks++;
        if (m0_rdata_o !== ref_rdata[0]) begin
            errors++; $display("FAIL t1_rdata: got %h want %h", m0_rdata_o, ref_rdata[0]);
        end
    endtask

    task automatic test_write_read();
        int a, e, n; bit er, oth;
        logic [DW-1:0] d;
        d = {8{32'h12345678}} ^ rnd_line() & {DW{1'b0}};
        run_txn(1, 1, 32'h80, d, 0, a, e, n, er, oth);
        ref_mem[4] = d;
        checks++; if (a !== 13) begin errors++; $display("FAIL t2_write_ack: got %0d want 13", a); end
        checks++;
        if (m1_rdata_o !== ref_rdata[1]) begin
            errors++; $display("FAIL t2_rdata_held: got %h want %h", m1_rdata_o, ref_rdata[1]);
        end
        run_txn(1, 0, 32'h80, '0, 0, a, e, n, er, oth);
        ref_rdata[1] = ref_mem[4];
        checks++;
        if (m1_rdata_o !== ref_rdata[1]) begin
            errors++; $display("FAIL t2_readback: got %h want %h", m1_rdata_o, ref_rdata[1]);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        do_reset();
        fork
            begin
                for (int n = 0; n < 2; n++) begin
                    bit got = 0;
                    @(negedge clk_i);
                    m0_req_i = 1; m0_write_i = 0; m0_addr_i = AW'((8 + n) << 5);
                    for (int k = 0; k < 80 && !got; k++) begin
                        @(negedge clk_i);
                        if (m0_ack_o) begin got = 1; order.push_back(0); m0_req_i = 0; end
                    end
                    if (!got) begin
                        m0_req_i = 0; checks++; errors++;
                        $display("FAIL t3_m0_starved: got no ack want ack");
                    end
                end
            end
            begin
                for (int n = 0; n < 2; n++) begin
                    bit got = 0;
                    @(negedge clk_i);
                    m1_req_i = 1; m1_write_i = 0; m1_addr_i = AW'((12 + n) << 5);
                    for (int k = 0; k < 80 && !got; k++) begin
                        @(negedge clk_i);
                        if (m1_ack_o) begin got = 1; order.push_back(1); m1_req_i = 0; end
                    end
                    if (!got) begin
                        m1_req_i = 0; checks++; errors++;
                        $display("FAIL t3_m1_starved: got no ack want ack");
                    end
                end
            end
        join
        ref_rdata[0] = ref_mem[9];
        ref_rdata[1] = ref_mem[13];
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL t3_grant_count: got %0d want 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != (i % 2)) begin
                    errors++; $display("FAIL t3_grant_order[%0d]: got m%0d want m%0d", i, order[i], i % 2);
                end
            end
        end
        checks++;
        if (m0_rdata_o !== ref_rdata[0] || m1_rdata_o !== ref_rdata[1]) begin
            errors++; $display("FAIL t3_rdata: got %h / %h want %h / %h",
                               m0_rdata_o, m1_rdata_o, ref_rdata[0], ref_rdata[1]);
        end
    endtask

    task automatic test_timeout();
        int a, e, n; bit er, oth;
        noack = 1;
        run_txn(0, 0, 32'hA0, '0, 0, a, e, n, er, oth);
        checks++; if (a !== 2 + TO) begin errors++; $display("FAIL t4_timeout_cycle: got %0d want %0d", a, 2 + TO); end
        checks++; if (er !== 1) begin errors++; $display("FAIL t4_err: got %0d want 1", er); end
        checks++;
        if (m0_rdata_o !== ref_rdata[0]) begin
            errors++; $display("FAIL t4_rdata_kept: got %h want %h", m0_rdata_o, ref_rdata[0]);
        end
        @(negedge clk_i);
        checks++; if (busy_o !== 0) begin errors++; $display("FAIL t4_busy_after: got %b want 0", busy_o); end
        noack = 0;
        run_txn(0, 0, 32'hA0, '0, 0, a, e, n, er, oth);
        ref_rdata[0] = ref_mem[5];
        checks++;
        if (a !== 13 || er !== 0 || m0_rdata_o !== ref_rdata[0]) begin
            errors++; $display("FAIL t4_recover: ack_cyc=%0d err=%0d rdata=%h want 13 0 %h",
                               a, er, m0_rdata_o, ref_rdata[0]);
        end
    endtask

    task automatic test_reset_mid();
        int a, e, n; bit er, oth, seen;
        @(negedge clk_i);
        m1_req_i = 1; m1_write_i = 0; m1_addr_i = 32'hC0;
        repeat (5) @(negedge clk_i);
        checks++; if (busy_o !== 1) begin errors++; $display("FAIL t5_busy_before: got %b want 1", busy_o); end
        #2 rst_i = 0;
        #1;
        checks++;
        if ({busy_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, m0_ack_o, m0_err_o,
             m1_ack_o, m1_err_o, m0_rdata_o, m1_rdata_o} !== '0) begin
            errors++; $display("FAIL t5_async_reset: busy=%b addr=%h not all zero", busy_o, mem_addr_o);
        end
        m1_req_i = 0;
        ref_rdata[0] = '0; ref_rdata[1] = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (m0_ack_o || m1_ack_o || busy_o) seen = 1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL t5_no_ack: got activity=1 want 0"); end
        run_txn(1, 0, 32'hE0, '0, 0, a, e, n, er, oth);
        ref_rdata[1] = ref_mem[7];
        checks++;
        if (a !== 13 || m1_rdata_o !== ref_rdata[1]) begin
            errors++; $display("FAIL t5_new_read: ack_cyc=%0d rdata=%h want 13 %h", a, m1_rdata_o, ref_rdata[1]);
        end
    endtask

    task automatic test_stray_ack();
        bit seen = 0;
        @(negedge clk_i);
        stray = 1;
        repeat (4) begin
            @(negedge clk_i);
            if (m0_ack_o || m1_ack_o || busy_o) seen = 1;
        end
        stray = 0;
        @(negedge clk_i);
        checks++; if (seen !== 0) begin errors++; $display("FAIL stray_ack: got activity=1 want 0"); end
    endtask

    task automatic test_addr_change();
        int a, e, n; bit er, oth;
        run_txn(0, 0, 32'h120, '0, 3, a, e, n, er, oth);
        ref_rdata[0] = ref_mem[9];
        checks++;
        if (seen_addr !== 32'h120) begin
            errors++; $display("FAIL t6_mem_addr: got %h want 00000120", seen_addr);
        end
        checks++;
        if (a !== 13 || m0_rdata_o !== ref_rdata[0]) begin
            errors++; $display("FAIL t6_rdata: ack_cyc=%0d rdata=%h want 13 %h", a, m0_rdata_o, ref_rdata[0]);
        end
    endtask

    task automatic test_random();
        int a, e, n; bit er, oth;
        for (int i = 0; i < 10; i++) begin
            int id, line;
            bit wr;
            logic [DW-1:0] d;
            id   = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            line = $urandom_range(16, 19);
            d    = rnd_line();
            run_txn(id, wr, AW'(line << 5), d, 0, a, e, n, er, oth);
            if (wr) ref_mem[line] = d;
            else    ref_rdata[id] = ref_mem[line];
            checks++;
            if (a !== 13 || er !== 0 || oth !== 0) begin
                errors++; $display("FAIL rnd%0d_handshake: ack_cyc=%0d err=%0d other=%0d want 13 0 0",
                                   i, a, er, oth);
            end
            checks++;
            if (m0_rdata_o !== ref_rdata[0] || m1_rdata_o !== ref_rdata[1]) begin
                errors++; $display("FAIL rnd%0d_rdata: got %h / %h want %h / %h", i,
                                   m0_rdata_o, m1_rdata_o, ref_rdata[0], ref_rdata[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = rnd_line();
            ref_mem[i] = mem[i];
        end
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        test_addr_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500us, want finished");
        $fatal(1);
    end

endmodule
